sound_ctrl_param: RTL and testbench

- Parametrised successor of the board-level note/volume controller.
- Selects a tone divider from NUM_NOTES priority-encoded note buttons.
- Keeps a saturating volume level with edge-detected, auto-repeating up/down buttons and a mute toggle.
- Drives the signed amplitude pair to the speaker/audio generator, plus a two-digit BCD level and an LED bar to the display path.

---
 rtl/sound_pkg.sv | 41 ++++
 rtl/btn_repeat.sv | 49 ++++
 rtl/sound_ctrl_param.sv | 113 +++++++++++
 tb/tb_sound_ctrl_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared constants and helpers for the note/volume controller family.
package sound_pkg;

  localparam int unsigned NOTE_TBL_N = 8;
  localparam int unsigned BAR_MAX_W  = 64;

  // Tone half-period dividers for a 100 MHz clock, C4..C5.
  localparam logic [19:0] NOTE_DIV [0:NOTE_TBL_N-1] = '{
    20'd191113, 20'd170262, 20'd151686, 20'd143173,
    20'd127551, 20'd113636, 20'd101238, 20'd95556
  };

  typedef enum logic [1:0] {
    VOL_HOLD = 2'b00,
    VOL_UP   = 2'b01,
    VOL_DN   = 2'b10
  } vol_op_e;

  function automatic logic [7:0] to_bcd(input int unsigned lvl);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(lvl / 10);
    ones = 4'(lvl % 10);
    return {tens, ones};
  endfunction

  // Bar of floor(lvl*led_w/level_max) ones, packed against bit led_w-1.
  function automatic logic [BAR_MAX_W-1:0] bar_fill(input int unsigned lvl,
                                                    input int unsigned led_w,
                                                    input int unsigned level_max);
    logic [BAR_MAX_W-1:0] bar;
    int unsigned          n;
    bar = '0;
    n   = (lvl * led_w) / level_max;
    for (int unsigned i = 0; i < BAR_MAX_W; i++) begin
      bar[i] = (i < led_w) && ((i + n) >= led_w);
    end
    return bar;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector with optional hold-to-repeat step generation.
module btn_repeat #(
  parameter int unsigned REPEAT_CYC = 25_000_000,
  parameter bit          REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step
);

  localparam int unsigned CW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(REPEAT_CYC - 1);

  logic          btn_q;
  logic          step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter restarts on the initial pulse so the first repeat lands
  // REPEAT_CYC cycles after it; release drops it back to zero.
  always_comb begin
    cnt_d  = '0;
    step_d = 1'b0;
    if (btn && !btn_q) begin
      step_d = 1'b1;
    end else if (btn && REPEAT_EN) begin
      if (cnt_q == LAST) begin
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= 1'b0;
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      btn_q  <= btn;
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/sound_ctrl_param.sv
// Note selection, saturating volume with auto-repeat, mute, and display outputs.
module sound_ctrl_param
  import sound_pkg::*;
#(
  parameter int unsigned NUM_NOTES   = 8,
  parameter int unsigned LEVEL_MAX   = 16,
  parameter int unsigned LEVEL_RESET = 1,
  parameter logic [15:0] STEP        = 16'h0400,
  parameter int unsigned LED_W       = 16,
  parameter int unsigned REPEAT_CYC  = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_NOTES-1:0] note_btn,
  input  logic                 enable,
  input  logic                 vol_up,
  input  logic                 vol_dn,
  input  logic                 mute_btn,
  output logic [19:0]          note_div,
  output logic                 note_on,
  output logic [31:0]          vol_level,
  output logic [3:0]           level_0,
  output logic [3:0]           level_1,
  output logic [LED_W-1:0]     led,
  output logic                 muted
);

  localparam int unsigned LW = $clog2(LEVEL_MAX + 1);

  if ((LEVEL_MAX * STEP) > 32'h7FFF || LEVEL_MAX > 99 || LEVEL_MAX < 1 ||
      NUM_NOTES > NOTE_TBL_N || NUM_NOTES < 1 || LEVEL_RESET > LEVEL_MAX ||
      LED_W > BAR_MAX_W || LED_W < 1) begin : g_param_err
    $error("sound_ctrl_param: illegal parameter combination");
  end

  logic          up_step, dn_step, mute_step;
  logic [19:0]   note_div_q, note_div_d;
  logic          note_on_q, note_on_d;
  logic [LW-1:0] level_q, level_d;
  logic          muted_q, muted_d;
  vol_op_e       vol_op;
  logic [15:0]   amp;

  btn_repeat #(.REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)) u_rep_up (
    .clk(clk), .rst_n(rst_n), .btn(vol_up), .step(up_step)
  );

  btn_repeat #(.REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)) u_rep_dn (
    .clk(clk), .rst_n(rst_n), .btn(vol_dn), .step(dn_step)
  );

  btn_repeat #(.REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0)) u_rep_mute (
    .clk(clk), .rst_n(rst_n), .btn(mute_btn), .step(mute_step)
  );

  // Lowest set button wins; the on-flag doubles as the "already found" mark.
  always_comb begin
    note_div_d = '0;
    note_on_d  = 1'b0;
    if (enable) begin
      for (int unsigned i = 0; i < NUM_NOTES; i++) begin
        if (note_btn[i] && !note_on_d) begin
          note_div_d = NOTE_DIV[i];
          note_on_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case ({dn_step, up_step})
      2'b01:   vol_op = VOL_UP;
      2'b10:   vol_op = VOL_DN;
      default: vol_op = VOL_HOLD;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case (vol_op)
      VOL_UP:   if (level_q != LW'(LEVEL_MAX)) level_d = level_q + 1'b1;
      VOL_DN:   if (level_q != '0)             level_d = level_q - 1'b1;
      default:  level_d = level_q;
    endcase
  end

  assign muted_d = muted_q ^ mute_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_div_q <= '0;
      note_on_q  <= 1'b0;
      level_q    <= LW'(LEVEL_RESET);
      muted_q    <= 1'b0;
    end else begin
      note_div_q <= note_div_d;
      note_on_q  <= note_on_d;
      level_q    <= level_d;
      muted_q    <= muted_d;
    end
  end

  assign amp       = muted_q ? '0 : 16'(32'(level_q) * 32'(STEP));
  assign vol_level = {amp, 16'(~amp + 16'd1)};

  assign {level_1, level_0} = to_bcd(32'(level_q));
  assign led                = LED_W'(bar_fill(32'(level_q), LED_W, LEVEL_MAX));

  assign note_div = note_div_q;
  assign note_on  = note_on_q;
  assign muted    = muted_q;

endmodule

// File: tb/tb_sound_ctrl_param.sv
// Randomised and directed checks of sound_ctrl_param against a behavioural model.
module tb_sound_ctrl_param;

  localparam int unsigned RC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  note_btn = '0;
  logic        enable = 1'b0;
  logic        vol_up = 1'b0;
  logic        vol_dn = 1'b0;
  logic        mute_btn = 1'b0;
  logic [19:0] note_div;
  logic        note_on;
  logic [31:0] vol_level;
  logic [3:0]  level_0, level_1;
  logic [15:0] led;
  logic        muted;

  int checks = 0;
  int errors = 0;

  sound_ctrl_param #(.REPEAT_CYC(RC)) dut (
    .clk(clk), .rst_n(rst_n), .note_btn(note_btn), .enable(enable),
    .vol_up(vol_up), .vol_dn(vol_dn), .mute_btn(mute_btn),
    .note_div(note_div), .note_on(note_on), .vol_level(vol_level),
    .level_0(level_0), .level_1(level_1), .led(led), .muted(muted)
  );

  always #5 clk = ~clk;

  logic [19:0] tbl [0:7] = '{20'd191113, 20'd170262, 20'd151686, 20'd143173,
                             20'd127551, 20'd113636, 20'd101238, 20'd95556};

  // Model: a button held for h consecutive sampled edges issues a step on
  // h = 1, 1+RC, 1+2*RC, ...; a step moves the level on the following edge.
  int          m_level;
  bit          m_muted, mu_prev, up_p, dn_p, mu_p, m_on;
  int          up_h, dn_h;
  logic [19:0] m_div;

  task automatic model_reset();
    m_level = 1; m_muted = 0; mu_prev = 0; up_p = 0; dn_p = 0; mu_p = 0;
    up_h = 0; dn_h = 0; m_div = '0; m_on = 0;
  endtask

  task automatic model_edge();
    if (up_p && !dn_p) m_level = (m_level < 16) ? m_level + 1 : 16;
    if (dn_p && !up_p) m_level = (m_level > 0) ? m_level - 1 : 0;
    if (mu_p) m_muted = !m_muted;
    up_h = vol_up ? up_h + 1 : 0;
    dn_h = vol_dn ? dn_h + 1 : 0;
    up_p = vol_up && ((up_h - 1) % RC == 0);
    dn_p = vol_dn && ((dn_h - 1) % RC == 0);
    mu_p = mute_btn && !mu_prev;
    mu_prev = mute_btn;
    m_on = enable && (note_btn != 0);
    m_div = '0;
    if (m_on) begin
      for (int i = 7; i >= 0; i--) if (note_btn[i]) m_div = tbl[i];
    end
  endtask

  function automatic logic [31:0] exp_vol(int lvl, bit mt);
    logic [15:0] a;
    a = mt ? 16'd0 : 16'(lvl * 1024);
    return {a, 16'(16'd0 - a)};
  endfunction

  function automatic logic [15:0] exp_led(int lvl);
    logic [31:0] s;
    s = 32'hFFFF_0000 >> lvl;
    return s[15:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic press_up();
    vol_up = 1; cyc(); cyc(); vol_up = 0; cyc(); cyc();
  endtask

  task automatic press_dn();
    vol_dn = 1; cyc(); cyc(); vol_dn = 0; cyc(); cyc();
  endtask

  task automatic pulse_mute();
    mute_btn = 1; cyc(); cyc(); mute_btn = 0; cyc(); cyc();
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    repeat (3) cyc();
    rst_n = 1; #2;
    checks++; if (level_1 !== 4'd0 || level_0 !== 4'd1) begin errors++;
      $display("FAIL reset_bcd got %0d%0d exp 01", level_1, level_0); end
    checks++; if (vol_level !== 32'h0400_FC00) begin errors++;
      $display("FAIL reset_vol got %h exp 0400fc00", vol_level); end
    checks++; if (led !== 16'h8000) begin errors++;
      $display("FAIL reset_led got %h exp 8000", led); end
    checks++; if (note_div !== 20'd0 || note_on !== 1'b0 || muted !== 1'b0) begin errors++;
      $display("FAIL reset_misc got div=%0d on=%b mute=%b exp 0/0/0", note_div, note_on, muted); end
  endtask

  task automatic test_note();
    enable = 1; note_btn = 8'b0000_0110; cyc();
    checks++; if (note_div !== 20'd170262 || note_on !== 1'b1) begin errors++;
      $display("FAIL note_prio got div=%0d on=%b exp 170262/1", note_div, note_on); end
    enable = 0; cyc();
    checks++; if (note_div !== 20'd0 || note_on !== 1'b0) begin errors++;
      $display("FAIL note_off got div=%0d on=%b exp 0/0", note_div, note_on); end
    note_btn = '0;
  endtask

  task automatic test_up_sat();
    repeat (20) press_up();
    checks++; if (level_1 !== 4'd1 || level_0 !== 4'd6) begin errors++;
      $display("FAIL up_sat_bcd got %0d%0d exp 16", level_1, level_0); end
    checks++; if (led !== 16'hFFFF || vol_level !== 32'h4000_C000) begin errors++;
      $display("FAIL up_sat_out got led=%h vol=%h exp ffff/4000c000", led, vol_level); end
    press_up();
    checks++; if (level_1 !== 4'd1 || level_0 !== 4'd6 || vol_level !== 32'h4000_C000) begin
      errors++; $display("FAIL up_sat_extra got %0d%0d vol=%h exp 16/4000c000",
                         level_1, level_0, vol_level); end
  endtask

  task automatic test_down_floor();
    bit seen_zero = 0;
    vol_dn = 1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      checks++; if (level_1 !== 4'(m_level / 10) || level_0 !== 4'(m_level % 10)) begin
        errors++; $display("FAIL down_track cyc=%0d got %0d%0d exp %0d", i, level_1, level_0, m_level); end
      if (seen_zero) begin
        checks++; if (level_0 !== 4'd0 || level_1 !== 4'd0) begin errors++;
          $display("FAIL down_wrap cyc=%0d got %0d%0d exp 0", i, level_1, level_0); end
      end
      if (level_0 === 4'd0 && level_1 === 4'd0) seen_zero = 1;
    end
    vol_dn = 0; cyc(); cyc();
    checks++; if (led !== 16'h0000 || vol_level !== 32'h0 || level_0 !== 4'd0) begin errors++;
      $display("FAIL down_floor got led=%h vol=%h lvl=%0d exp 0/0/0", led, vol_level, level_0); end
  endtask

  task automatic test_simul();
    repeat (5) press_up();
    vol_up = 1; vol_dn = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++; if (level_1 !== 4'd0 || level_0 !== 4'd5) begin errors++;
        $display("FAIL simul cyc=%0d got %0d%0d exp 05", i, level_1, level_0); end
    end
    vol_up = 0; vol_dn = 0; cyc(); cyc();
  endtask

  task automatic test_mute();
    press_dn(); press_dn();
    pulse_mute();
    checks++; if (muted !== 1'b1 || vol_level !== 32'h0 || led !== 16'hE000) begin errors++;
      $display("FAIL mute_on got m=%b vol=%h led=%h exp 1/0/e000", muted, vol_level, led); end
    press_up();
    checks++; if (level_0 !== 4'd4 || vol_level !== 32'h0) begin errors++;
      $display("FAIL mute_level got lvl=%0d vol=%h exp 4/0", level_0, vol_level); end
    pulse_mute();
    checks++; if (muted !== 1'b0 || vol_level !== 32'h1000_F000) begin errors++;
      $display("FAIL mute_off got m=%b vol=%h exp 0/1000f000", muted, vol_level); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) vol_up = ~vol_up;
      if ($urandom_range(11) == 0) vol_dn = ~vol_dn;
      if ($urandom_range(15) == 0) mute_btn = ~mute_btn;
      if ($urandom_range(5) == 0) enable = 1'($urandom);
      if ($urandom_range(5) == 0) note_btn = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
      if (i == 1500) begin
        rst_n = 0; #2;
        checks++; if (note_on !== 1'b0 || muted !== 1'b0 || level_0 !== 4'd1 || level_1 !== 4'd0) begin
          errors++; $display("FAIL rnd_async_rst got on=%b m=%b lvl=%0d%0d exp 0/0/01",
                             note_on, muted, level_1, level_0); end
        model_reset(); cyc(); rst_n = 1;
      end
      cyc();
      checks++; if (note_div !== m_div || note_on !== m_on) begin errors++;
        $display("FAIL rnd_note cyc=%0d got %0d/%b exp %0d/%b", i, note_div, note_on, m_div, m_on); end
      checks++; if (level_1 !== 4'(m_level / 10) || level_0 !== 4'(m_level % 10)) begin errors++;
        $display("FAIL rnd_level cyc=%0d got %0d%0d exp %0d", i, level_1, level_0, m_level); end
      checks++; if (muted !== m_muted || vol_level !== exp_vol(m_level, m_muted)) begin errors++;
        $display("FAIL rnd_vol cyc=%0d got m=%b %h exp m=%b %h", i, muted, vol_level,
                 m_muted, exp_vol(m_level, m_muted)); end
      checks++; if (led !== exp_led(m_level)) begin errors++;
        $display("FAIL rnd_led cyc=%0d got %h exp %h", i, led, exp_led(m_level)); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_note();
    test_up_sat();
    test_down_floor();
    test_simul();
    test_mute();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
